// File: rtl/ap_mult_err_eval_if.sv
// Bus between the error-evaluation engine and the approximate multiplier / host.
// The master side is the engine: it drives operands and statistics, and receives start and ap_prod.
interface ap_mult_err_eval_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned SUM_W = 48
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 op_valid;
    logic [2*WIDTH-1:0]   ap_prod;
    logic [CNT_W-1:0]     err_cnt;
    logic [SUM_W-1:0]     err_sum;
    logic [2*WIDTH-1:0]   max_err;
    logic [WIDTH-1:0]     max_a;
    logic [WIDTH-1:0]     max_b;

    modport master (
        input  start, ap_prod,
        output busy, done, op_a, op_b, op_valid,
               err_cnt, err_sum, max_err, max_a, max_b
    );

    modport slave (
        output start, ap_prod,
        input  busy, done, op_a, op_b, op_valid,
               err_cnt, err_sum, max_err, max_a, max_b
    );
endinterface

// File: rtl/ap_mult_err_eval.sv
// Exhaustive operand sweep of an external approximate multiplier, comparing each returned
// product against the exact one and accumulating saturating error statistics.
module ap_mult_err_eval #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned SUM_W = 48
) (
    input logic                clk,
    input logic                rst,
    ap_mult_err_eval_if.master bus
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned STG_W = 2 * WIDTH + 1;
    localparam int unsigned SW1   = SUM_W + 1;
    localparam logic [2:0]  DRAIN_LOAD = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [2:0]      drain_cnt;
    logic            accept;
    logic            enter_drain;
    logic            last_pair;

    logic [STG_W-1:0] cur;
    logic [STG_W-1:0] chk;
    logic             chk_valid;
    logic [WIDTH-1:0] chk_a;
    logic [WIDTH-1:0] chk_b;
    logic [PW-1:0]    exact;
    logic [PW-1:0]    err;
    logic [SW1-1:0]   sum_nx;

    assign last_pair = (bus.op_a == '1) && (bus.op_b == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        enter_drain = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = SWEEP;
                end
            end
            SWEEP: begin
                bus.busy = 1'b1;
                if (last_pair) begin
                    // With no multiplier latency the final check already happens in SWEEP.
                    if (LAT == 0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx    = DRAIN;
                        enter_drain = 1'b1;
                    end
                end
            end
            DRAIN: begin
                bus.busy = 1'b1;
                if (drain_cnt == 3'd0) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.op_a     <= '0;
            bus.op_b     <= '0;
            bus.op_valid <= 1'b0;
            drain_cnt    <= 3'd0;
        end else begin
            if (accept) begin
                bus.op_a     <= '0;
                bus.op_b     <= '0;
                bus.op_valid <= 1'b1;
            end else if (state == SWEEP) begin
                if (last_pair) begin
                    bus.op_valid <= 1'b0;
                end else begin
                    {bus.op_a, bus.op_b} <= {bus.op_a, bus.op_b} + PW'(1);
                end
            end
            if (enter_drain) begin
                drain_cnt <= DRAIN_LOAD;
            end else if ((state == DRAIN) && (drain_cnt != 3'd0)) begin
                drain_cnt <= drain_cnt - 3'd1;
            end
        end
    end

    assign cur = {bus.op_valid, bus.op_a, bus.op_b};

    generate
        if (LAT == 0) begin : g_nodly
            assign chk = cur;
        end else begin : g_dly
            logic [STG_W-1:0] dl [LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < LAT; i++) begin
                        dl[i] <= '0;
                    end
                end else begin
                    dl[0] <= cur;
                    for (int unsigned i = 1; i < LAT; i++) begin
                        dl[i] <= dl[i-1];
                    end
                end
            end
            assign chk = dl[LAT-1];
        end
    endgenerate

    assign chk_valid = chk[STG_W-1];
    assign chk_a     = chk[PW-1:WIDTH];
    assign chk_b     = chk[WIDTH-1:0];
    assign exact     = PW'(chk_a) * PW'(chk_b);
    assign err       = (bus.ap_prod >= exact) ? (bus.ap_prod - exact) : (exact - bus.ap_prod);
    assign sum_nx    = {1'b0, bus.err_sum} + SW1'(err);

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            bus.err_cnt <= '0;
            bus.err_sum <= '0;
            bus.max_err <= '0;
            bus.max_a   <= '0;
            bus.max_b   <= '0;
        end else if (chk_valid && (err != '0)) begin
            if (bus.err_cnt != '1) begin
                bus.err_cnt <= bus.err_cnt + CNT_W'(1);
            end
            bus.err_sum <= sum_nx[SUM_W] ? '1 : sum_nx[SUM_W-1:0];
            // Strict compare keeps the first pair that reached the maximum.
            if (err > bus.max_err) begin
                bus.max_err <= err;
                bus.max_a   <= chk_a;
                bus.max_b   <= chk_b;
            end
        end
    end
endmodule

// File: tb/tb_ap_mult_err_eval.sv
// Directed bench: six engines swept in parallel against exact, LSB-stuck, zero and mis-timed
// multiplier models, plus mid-sweep reset and start-filtering scenarios.
module tb_ap_mult_err_eval;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    logic rst_f;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned f_dones  = 0;
    int unsigned a_dones  = 0;

    always #5 clk = ~clk;

    ap_mult_err_eval_if #(.WIDTH(W), .CNT_W(32), .SUM_W(48)) ia ();
    ap_mult_err_eval_if #(.WIDTH(W), .CNT_W(32), .SUM_W(48)) ib ();
    ap_mult_err_eval_if #(.WIDTH(W), .CNT_W(32), .SUM_W(48)) ic ();
    ap_mult_err_eval_if #(.WIDTH(W), .CNT_W(32), .SUM_W(48)) id ();
    ap_mult_err_eval_if #(.WIDTH(W), .CNT_W(32), .SUM_W(48)) ie ();
    ap_mult_err_eval_if #(.WIDTH(W), .CNT_W(32), .SUM_W(48)) if_f ();

    ap_mult_err_eval #(.WIDTH(W), .LAT(1), .CNT_W(32), .SUM_W(48)) u_a (.clk(clk), .rst(rst),   .bus(ia.master));
    ap_mult_err_eval #(.WIDTH(W), .LAT(1), .CNT_W(32), .SUM_W(48)) u_b (.clk(clk), .rst(rst),   .bus(ib.master));
    ap_mult_err_eval #(.WIDTH(W), .LAT(0), .CNT_W(32), .SUM_W(48)) u_c (.clk(clk), .rst(rst),   .bus(ic.master));
    ap_mult_err_eval #(.WIDTH(W), .LAT(3), .CNT_W(32), .SUM_W(48)) u_d (.clk(clk), .rst(rst),   .bus(id.master));
    ap_mult_err_eval #(.WIDTH(W), .LAT(3), .CNT_W(32), .SUM_W(48)) u_e (.clk(clk), .rst(rst),   .bus(ie.master));
    ap_mult_err_eval #(.WIDTH(W), .LAT(1), .CNT_W(32), .SUM_W(48)) u_f (.clk(clk), .rst(rst_f), .bus(if_f.master));

    function automatic logic [15:0] mul(input logic [7:0] a, input logic [7:0] b);
        return {8'd0, a} * {8'd0, b};
    endfunction

    logic [15:0] d1, d2, e1;

    // Multiplier models: exact/1, LSB-stuck/1, exact/3, exact but only 2 cycles deep.
    always @(posedge clk) begin
        ia.ap_prod <= mul(ia.op_a, ia.op_b);
        ib.ap_prod <= mul(ib.op_a, ib.op_b) & 16'hFFFE;
        d1         <= mul(id.op_a, id.op_b);
        d2         <= d1;
        id.ap_prod <= d2;
        e1         <= mul(ie.op_a, ie.op_b);
        ie.ap_prod <= e1;
    end
    assign ic.ap_prod   = '0;
    assign if_f.ap_prod = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        rst_f = 1'b1;
        ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
        id.start = 1'b0; ie.start = 1'b0; if_f.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ctl",   {ia.busy, ia.done, ia.op_valid, ia.op_a, ia.op_b}, 64'd0);
        check("rst_a_stats", {ia.err_cnt, ia.max_err, ia.max_a, ia.max_b}, 64'd0);
        check("rst_a_sum",   ia.err_sum, 64'd0);
        check("rst_c_ctl",   {ic.busy, ic.done, ic.op_valid, ic.op_a, ic.op_b}, 64'd0);
        rst = 1'b0;
        rst_f = 1'b0;

        for (int unsigned cyc = 0; cyc <= 65545; cyc++) begin
            if (if_f.done) f_dones++;
            if (ia.done) a_dones++;
            case (cyc)
                0: begin
                    ia.start = 1'b1; ib.start = 1'b1; ic.start = 1'b1;
                    id.start = 1'b1; ie.start = 1'b1; if_f.start = 1'b1;
                end
                1: begin
                    ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
                    id.start = 1'b0; ie.start = 1'b0; if_f.start = 1'b0;
                    check("a_first_pair", {ia.busy, ia.op_valid, ia.op_a, ia.op_b}, {2'b11, 8'd0, 8'd0});
                    check("c_busy_c1", {ic.busy, ic.done}, 2'b10);
                end
                2:   check("a_pair1",   {ia.op_a, ia.op_b}, {8'd0, 8'd1});
                257: check("a_b_wrap",  {ia.op_a, ia.op_b}, {8'd1, 8'd0});
                500: ia.start = 1'b1;
                501: begin
                    ia.start = 1'b0;
                    check("a_start_busy_ign", {ia.busy, ia.op_valid, ia.op_a, ia.op_b}, {2'b11, 8'd1, 8'd244});
                end
                1000: begin
                    rst_f = 1'b1;
                    check("f_cnt_c1000", if_f.err_cnt, 64'd739);
                    check("f_max_c1000", {if_f.max_err, if_f.max_a, if_f.max_b}, {16'd687, 8'd3, 8'd229});
                end
                1001: begin
                    rst_f = 1'b0;
                    check("f_abort_ctl",   {if_f.busy, if_f.done, if_f.op_valid, if_f.op_a, if_f.op_b}, 64'd0);
                    check("f_abort_stats", {if_f.err_cnt, if_f.max_err, if_f.max_a, if_f.max_b}, 64'd0);
                    check("f_abort_sum",   if_f.err_sum, 64'd0);
                end
                65536: check("c_busy_last", {ic.busy, ic.done}, 2'b10);
                65537: begin
                    check("c_done",     {ic.busy, ic.done}, 2'b01);
                    check("c_err_cnt",  ic.err_cnt, 64'd65025);
                    check("c_err_sum",  ic.err_sum, 64'd1065369600);
                    check("c_max",      {ic.max_err, ic.max_a, ic.max_b}, {16'd65025, 8'd255, 8'd255});
                    check("a_busy_end", {ia.busy, ia.done}, 2'b10);
                end
                65538: begin
                    check("a_done",     {ia.busy, ia.done}, 2'b01);
                    check("a_stats",    {ia.err_cnt, ia.max_err, ia.max_a, ia.max_b}, 64'd0);
                    check("a_sum",      ia.err_sum, 64'd0);
                    check("b_done",     ib.done, 1'b1);
                    check("b_err_cnt",  ib.err_cnt, 64'd16384);
                    check("b_err_sum",  ib.err_sum, 64'd16384);
                    check("b_max",      {ib.max_err, ib.max_a, ib.max_b}, {16'd1, 8'd1, 8'd1});
                    check("c_idle",     {ic.busy, ic.done}, 2'b00);
                    check("c_hold_cnt", ic.err_cnt, 64'd65025);
                    ia.start = 1'b1;
                    ic.start = 1'b1;
                end
                65539: begin
                    ic.start = 1'b0;
                    check("a_start_done_ign", {ia.busy, ia.done}, 2'b00);
                    check("c_restart",  {ic.busy, ic.op_valid}, 2'b11);
                    check("c_clr_stat", {ic.err_cnt, ic.max_err, ic.max_a, ic.max_b}, 64'd0);
                    check("c_clr_sum",  ic.err_sum, 64'd0);
                    check("d_busy_end", {id.busy, id.done}, 2'b10);
                end
                65540: begin
                    ia.start = 1'b0;
                    check("a_b2b_start", {ia.busy, ia.op_valid, ia.op_a, ia.op_b}, {2'b11, 8'd0, 8'd0});
                    check("d_done",      {id.busy, id.done}, 2'b01);
                    check("d_stats",     {id.err_cnt, id.max_err, id.max_a, id.max_b}, 64'd0);
                    check("d_sum",       id.err_sum, 64'd0);
                    check("e_bad_delay", (ie.err_cnt != 0), 1'b1);
                end
                default: ;
            endcase
            @(posedge clk);
            #1;
        end

        check("f_no_done",   f_dones, 64'd0);
        check("f_idle",      {if_f.busy, if_f.op_valid}, 2'b00);
        check("a_done_once", a_dones, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
